aq_ifu_ibuf_queue: RTL and testbench

Halfword-granular instruction buffer between the IFU fetch packer (ipack) and IDU.
- Accepts up to two 16-bit parcels per cycle from ipack and realigns them into one RVC or 32-bit instruction per cycle for IDU.
- Produces the fetch-request qualifier consumed by IFU control.
- Consumes the IFU control pop enable and cancel.
- Tracks the PC of the head instruction.

---
 rtl/aq_ifu_ibuf_pkg.sv | 13 +
 rtl/aq_ifu_ibuf_align.sv | 25 ++
 rtl/aq_ifu_ibuf_queue.sv | 101 ++++++++++
 tb/tb_aq_ifu_ibuf_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aq_ifu_ibuf_pkg.sv
// Shared constants and helpers for the IFU halfword instruction buffer.
package aq_ifu_ibuf_pkg;
    localparam int HW_W      = 16;
    localparam int DEPTH     = 8;
    localparam int PTR_W     = 3;
    localparam int FETCH_THR = 6;
    localparam int PC_W      = 39;

    // Any halfword whose two low bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction
endpackage

// File: rtl/aq_ifu_ibuf_align.sv
// Head realignment: turns the two oldest halfwords into one RVC or 32-bit instruction.
module aq_ifu_ibuf_align
    import aq_ifu_ibuf_pkg::*;
(
    input  logic [HW_W-1:0] hw0,
    input  logic [HW_W-1:0] hw1,
    input  logic [PTR_W:0]  count,
    output logic            rvc,
    output logic [1:0]      need,
    output logic            inst_vld,
    output logic [31:0]     inst
);
    always_comb begin
        rvc      = 1'b0;
        need     = 2'd0;
        inst_vld = 1'b0;
        inst     = 32'd0;
        if (count != '0) begin
            rvc      = is_rvc(hw0[1:0]);
            need     = rvc ? 2'd1 : 2'd2;
            inst_vld = count >= {{(PTR_W-1){1'b0}}, need};
            inst     = rvc ? {16'd0, hw0} : {hw1, hw0};
        end
    end
endmodule

// File: rtl/aq_ifu_ibuf_queue.sv
// Halfword-granular instruction buffer between ipack and IDU, with head PC tracking.
module aq_ifu_ibuf_queue
    import aq_ifu_ibuf_pkg::*;
(
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            ipack_ibuf_vld,
    input  logic [31:0]     ipack_ibuf_data,
    input  logic [1:0]      ipack_ibuf_hw_vld,
    input  logic [PC_W-1:0] ipack_ibuf_pc,
    input  logic            ctrl_ibuf_cancel,
    input  logic            ctrl_ibuf_pop_en,
    output logic            ibuf_ctrl_inst_fetch,
    output logic            ibuf_idu_inst_vld,
    output logic [31:0]     ibuf_idu_inst,
    output logic [PC_W-1:0] ibuf_idu_pc,
    output logic            ibuf_idu_inst_rvc
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] THR_C   = (PTR_W+1)'(FETCH_THR);

    logic [HW_W-1:0]  mem_q [DEPTH];
    logic [HW_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_nxt;
    logic [PTR_W:0]   count_q, count_d;
    logic [PC_W-1:0]  head_pc_q, head_pc_d;

    logic        rvc, inst_vld;
    logic [1:0]  need, nwr, nwr_eff, npop;
    logic [31:0] inst;
    logic [PTR_W:0]  avail, cnt_pop;
    logic [HW_W-1:0] first_hw;

    assign rptr_nxt = rptr_q + PTR_W'(1);

    aq_ifu_ibuf_align u_align (
        .hw0      (mem_q[rptr_q]),
        .hw1      (mem_q[rptr_nxt]),
        .count    (count_q),
        .rvc      (rvc),
        .need     (need),
        .inst_vld (inst_vld),
        .inst     (inst)
    );

    always_comb begin
        nwr      = ipack_ibuf_vld ? ({1'b0, ipack_ibuf_hw_vld[0]} + {1'b0, ipack_ibuf_hw_vld[1]}) : 2'd0;
        npop     = (inst_vld && ctrl_ibuf_pop_en) ? need : 2'd0;
        cnt_pop  = count_q - (PTR_W+1)'(npop);
        avail    = DEPTH_C - cnt_pop;
        // Halfwords beyond the free space are dropped so count never exceeds DEPTH.
        nwr_eff  = ((PTR_W+1)'(nwr) > avail) ? avail[1:0] : nwr;
        first_hw = (ipack_ibuf_hw_vld == 2'b10) ? ipack_ibuf_data[31:16] : ipack_ibuf_data[15:0];

        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        head_pc_d = head_pc_q;

        if (ctrl_ibuf_cancel) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (nwr_eff != 2'd0) mem_d[wptr_q] = first_hw;
            if (nwr_eff == 2'd2) mem_d[wptr_q + PTR_W'(1)] = ipack_ibuf_data[31:16];
            wptr_d  = wptr_q + PTR_W'(nwr_eff);
            rptr_d  = rptr_q + PTR_W'(npop);
            count_d = cnt_pop + (PTR_W+1)'(nwr_eff);
            if (cnt_pop == '0 && nwr_eff != 2'd0)
                head_pc_d = ipack_ibuf_pc;
            else if (npop != 2'd0)
                head_pc_d = head_pc_q + PC_W'({npop, 1'b0});
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    assign ibuf_ctrl_inst_fetch = (DEPTH_C - count_q) >= THR_C;
    assign ibuf_idu_inst_vld    = inst_vld;
    assign ibuf_idu_inst        = inst;
    assign ibuf_idu_inst_rvc    = rvc;
    assign ibuf_idu_pc          = (count_q != '0) ? head_pc_q : '0;
endmodule

// File: tb/tb_aq_ifu_ibuf_queue.sv
// Randomized and directed bench for aq_ifu_ibuf_queue against a halfword-queue reference model.
module tb_aq_ifu_ibuf_queue;
    import aq_ifu_ibuf_pkg::*;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            ipack_vld;
    logic [31:0]     ipack_data;
    logic [1:0]      ipack_hw_vld;
    logic [PC_W-1:0] ipack_pc;
    logic            cancel;
    logic            pop_en;
    logic            inst_fetch;
    logic            inst_vld;
    logic [31:0]     inst;
    logic [PC_W-1:0] idu_pc;
    logic            inst_rvc;

    int checks   = 0;
    int failures = 0;
    bit do_chk   = 0;

    logic [15:0]     mq[$];
    logic [PC_W-1:0] m_pc;

    always #5 clk = ~clk;

    aq_ifu_ibuf_queue dut (
        .forever_cpuclk       (clk),
        .cpurst_b             (rst_b),
        .ipack_ibuf_vld       (ipack_vld),
        .ipack_ibuf_data      (ipack_data),
        .ipack_ibuf_hw_vld    (ipack_hw_vld),
        .ipack_ibuf_pc        (ipack_pc),
        .ctrl_ibuf_cancel     (cancel),
        .ctrl_ibuf_pop_en     (pop_en),
        .ibuf_ctrl_inst_fetch (inst_fetch),
        .ibuf_idu_inst_vld    (inst_vld),
        .ibuf_idu_inst        (inst),
        .ibuf_idu_pc          (idu_pc),
        .ibuf_idu_inst_rvc    (inst_rvc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int  n;
        bit  rvc_e;
        n = mq.size();
        if (n == 0) begin
            chk("empty_vld", 64'(inst_vld), 64'd0);
            chk("empty_inst", 64'(inst), 64'd0);
            chk("empty_rvc", 64'(inst_rvc), 64'd0);
        end else begin
            rvc_e = (mq[0][1:0] != 2'b11);
            chk("rvc", 64'(inst_rvc), 64'(rvc_e));
            chk("vld", 64'(inst_vld), 64'(rvc_e || n >= 2));
            if (rvc_e)
                chk("inst16", 64'(inst), {48'd0, mq[0]});
            else if (n >= 2)
                chk("inst32", 64'(inst), {32'd0, mq[1], mq[0]});
            chk("pc", 64'(idu_pc), 64'(m_pc));
        end
        chk("fetch", 64'(inst_fetch), 64'((8 - n) >= 6));
    endtask

    task automatic step(input bit v, input logic [1:0] hw, input logic [31:0] d,
                        input logic [PC_W-1:0] pc, input bit cx, input bit pe, input bit rb);
        int n, need, npop, nwr;
        ipack_vld    = v;
        ipack_hw_vld = hw;
        ipack_data   = d;
        ipack_pc     = pc;
        cancel       = cx;
        pop_en       = pe;
        rst_b        = rb;
        #4;
        if (do_chk) check_outputs();
        @(posedge clk);
        if (!rb) begin
            mq.delete();
            m_pc = '0;
        end else if (cx) begin
            mq.delete();
        end else begin
            n    = mq.size();
            npop = 0;
            if (n > 0) begin
                need = (mq[0][1:0] != 2'b11) ? 1 : 2;
                if (n >= need && pe) npop = need;
            end
            repeat (npop) void'(mq.pop_front());
            nwr = v ? (int'(hw[0]) + int'(hw[1])) : 0;
            if (mq.size() == 0 && nwr > 0) m_pc = pc;
            else if (npop > 0) m_pc = m_pc + PC_W'(2 * npop);
            if (v && hw[0]) mq.push_back(d[15:0]);
            if (v && hw[1]) mq.push_back(d[31:16]);
            if (nwr > 0) chk("no_overflow", 64'(mq.size() > 8), 64'd0);
        end
        #1;
    endtask

    task automatic idle(input bit pe);
        step(1'b0, 2'b00, 32'd0, '0, 1'b0, pe, 1'b1);
    endtask

    initial begin
        logic [1:0]      hw;
        logic [PC_W-1:0] rpc;
        bit              v;

        step(1'b0, 2'b00, 32'd0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 32'hFFFF_FFFF, '1, 1'b0, 1'b1, 1'b0);
        do_chk = 1;
        chk("rst_vld", 64'(inst_vld), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_pc", 64'(idu_pc), 64'd0);
        chk("rst_rvc", 64'(inst_rvc), 64'd0);
        chk("rst_fetch", 64'(inst_fetch), 64'd1);

        // Two RVC parcels, popped one per cycle
        step(1'b1, 2'b11, 32'h0001_4501, 39'h1000, 1'b0, 1'b0, 1'b1);
        chk("t1_vld", 64'(inst_vld), 64'd1);
        chk("t1_rvc", 64'(inst_rvc), 64'd1);
        chk("t1_inst", 64'(inst), 64'h0000_4501);
        chk("t1_pc", 64'(idu_pc), 64'h1000);
        idle(1'b1);
        chk("t1b_inst", 64'(inst), 64'h0000_0001);
        chk("t1b_pc", 64'(idu_pc), 64'h1002);
        idle(1'b1);

        // 32-bit instruction split across two packets
        step(1'b1, 2'b10, 32'h0513_0000, 39'h2002, 1'b0, 1'b1, 1'b1);
        chk("t2a_vld", 64'(inst_vld), 64'd0);
        step(1'b1, 2'b11, 32'h0000_0000, 39'h2004, 1'b0, 1'b0, 1'b1);
        chk("t2_vld", 64'(inst_vld), 64'd1);
        chk("t2_inst", 64'(inst), 64'h0000_0513);
        chk("t2_rvc", 64'(inst_rvc), 64'd0);
        chk("t2_pc", 64'(idu_pc), 64'h2002);
        step(1'b0, 2'b00, 32'd0, '0, 1'b1, 1'b0, 1'b1);

        // Fetch threshold
        step(1'b1, 2'b11, 32'h0001_0001, 39'h100, 1'b0, 1'b0, 1'b1);
        chk("t3_fetch2", 64'(inst_fetch), 64'd1);
        step(1'b1, 2'b01, 32'h0000_0001, 39'h104, 1'b0, 1'b0, 1'b1);
        chk("t3_fetch3", 64'(inst_fetch), 64'd0);
        idle(1'b1);
        chk("t3_fetch_back", 64'(inst_fetch), 64'd1);
        step(1'b0, 2'b00, 32'd0, '0, 1'b1, 1'b0, 1'b1);

        // Walk pointers to 7, then a 32-bit instruction straddling the wrap
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 32'h0001_0001, 39'h400, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b01, 32'h0000_0001, 39'h406, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) idle(1'b1);
        step(1'b1, 2'b11, 32'h1234_0013, 39'h5000, 1'b0, 1'b0, 1'b1);
        chk("t4_inst", 64'(inst), 64'h1234_0013);
        chk("t4_rvc", 64'(inst_rvc), 64'd0);
        chk("t4_pc", 64'(idu_pc), 64'h5000);
        idle(1'b1);
        step(1'b1, 2'b01, 32'h0000_0002, 39'h6000, 1'b0, 1'b0, 1'b1);
        chk("t4_after_wrap", 64'(inst), 64'h0000_0002);

        // Cancel beats same-cycle write and pop
        step(1'b0, 2'b00, 32'd0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b11, 32'h0001_0001, 39'h700, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 32'h0001_0001, 39'h704, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 32'h0002_0002, 39'h708, 1'b1, 1'b1, 1'b1);
        chk("t5_vld", 64'(inst_vld), 64'd0);
        chk("t5_fetch", 64'(inst_fetch), 64'd1);
        step(1'b1, 2'b01, 32'h0000_0005, 39'h3000, 1'b0, 1'b0, 1'b1);
        chk("t5_pc", 64'(idu_pc), 64'h3000);

        // Reset mid-stream with five halfwords held
        step(1'b1, 2'b11, 32'h0001_0001, 39'h3002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 32'h0001_0001, 39'h3006, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 32'h0003_0007, 39'h300A, 1'b0, 1'b1, 1'b0);
        chk("t6_vld", 64'(inst_vld), 64'd0);
        chk("t6_inst", 64'(inst), 64'd0);
        chk("t6_pc", 64'(idu_pc), 64'd0);
        chk("t6_rvc", 64'(inst_rvc), 64'd0);
        chk("t6_fetch", 64'(inst_fetch), 64'd1);

        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(3, 0) != 0) && (mq.size() <= 6);
            hw  = 2'($urandom_range(3, 1));
            rpc = PC_W'({$urandom(), $urandom()});
            step(v, hw, $urandom(), rpc, ($urandom_range(31, 0) == 0),
                 ($urandom_range(3, 0) != 0), ($urandom_range(63, 0) != 0));
        end
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
